pix_frame_decoder: RTL and testbench

// - Evaluator-side reader for the garbled display output.
// - Consumes successive pix frames (WIDTH*HEIGHT bits each, streamed WORD pixels/beat).
// - Accumulates a per-pixel hit count over NB_FRAMES frames, then streams out the thresholded bitmap.
// - Recovers the segments lit with probability p (0.7) from the random per-frame pattern; used by benches and the demo viewer.

---
 rtl/pix_frame_decoder.sv | 77 +++++++
 tb/tb_pix_frame_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pix_frame_decoder.sv
// pix_frame_decoder: accumulates per-pixel hits over NB_FRAMES frames, then streams the thresholded bitmap; ports clk, rst (async, active-high), in_valid/in_ready/in_pix/in_last (frame input), out_valid/out_ready/out_pix/out_last (decoded output), frame_err (1-cycle in_last misalignment pulse), watmk (only when PIXDEC_WATERMARK_EN is defined)
module pix_frame_decoder #(
  parameter int WIDTH = 120,
  parameter int HEIGHT = 52,
  parameter int WORD = 8,
  parameter int NB_FRAMES = 16,
  parameter int THRESHOLD = 10,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_pix,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_pix,
  output logic             out_last,
  output logic             frame_err
`ifdef PIXDEC_WATERMARK_EN
  ,
  input  logic [WIDTH*HEIGHT-1:0] watmk
`endif
);
  localparam int NB_BEATS = WIDTH * HEIGHT / WORD;
  localparam int BW = NB_BEATS > 1 ? $clog2(NB_BEATS) : 1;
  localparam int FW = NB_FRAMES > 1 ? $clog2(NB_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat;
  logic [FW-1:0] frm;
  logic [CNT_W-1:0] cnt [NB_BEATS][WORD];
  logic in_fire, out_fire, beat_end, frame_end, last_frame;
  logic [WORD-1:0] thr, mask;
  always_comb begin
    in_ready = state == ACCUM;
    out_valid = state == DRAIN;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    beat_end = beat == BW'(NB_BEATS - 1);
    frame_end = in_last || beat_end;
    last_frame = frm == FW'(NB_FRAMES - 1);
    out_last = out_valid && beat_end;
    thr = '0;
    for (int i = 0; i < WORD; i++) thr[i] = int'(cnt[beat][i]) >= THRESHOLD;
`ifdef PIXDEC_WATERMARK_EN
    mask = watmk[beat*WORD +: WORD];
`else
    mask = '0;
`endif
    out_pix = out_valid ? thr & ~mask : '0;
    state_nx = state == IDLE ? ACCUM
             : (in_fire && frame_end && last_frame) ? DRAIN
             : (out_fire && beat_end) ? ACCUM
             : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // The beat index doubles as the drain index k: input and output never overlap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat <= '0;
      frm <= '0;
      frame_err <= 1'b0;
      for (int b = 0; b < NB_BEATS; b++)
        for (int i = 0; i < WORD; i++) cnt[b][i] <= '0;
    end else begin
      frame_err <= in_fire && (in_last != beat_end);
      if (in_fire || out_fire) beat <= (in_fire ? frame_end : beat_end) ? '0 : beat + BW'(1);
      if (in_fire && frame_end) frm <= last_frame ? '0 : frm + FW'(1);
      for (int i = 0; i < WORD; i++)
        if (in_fire) cnt[beat][i] <= &cnt[beat][i] ? cnt[beat][i] : cnt[beat][i] + CNT_W'(in_pix[i]);
        else if (out_fire) cnt[beat][i] <= '0;
    end
endmodule

// File: tb/tb_pix_frame_decoder.sv
// tb_pix_frame_decoder: directed table-driven bench for pix_frame_decoder in a 4x2, 4-pixel-beat, 4-frame configuration
module tb_pix_frame_decoder;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_pix = '0;
  logic in_ready, out_valid, out_last, frame_err;
  logic [3:0] out_pix;
`ifdef PIXDEC_WATERMARK_EN
  logic [7:0] watmk = '0;
`endif
  int pass_n = 0, tot_n = 0;

  pix_frame_decoder #(.WIDTH(4), .HEIGHT(2), .WORD(4), .NB_FRAMES(4), .THRESHOLD(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_last(out_last), .frame_err(frame_err)
`ifdef PIXDEC_WATERMARK_EN
    , .watmk(watmk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [3:0] p, input logic l);
    int n = 0;
    in_valid = 1; in_pix = p; in_last = l;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic frame(input logic [3:0] p0, input logic [3:0] p1);
    send(p0, 0);
    send(p1, 1);
  endtask

  task automatic recv(input string name, input logic [3:0] e, input logic el);
    int n = 0;
    out_ready = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_pix"}, out_pix, e);
    chk({name, "_last"}, out_last, el);
    @(negedge clk);
  endtask

  task automatic done(input string name);
    out_ready = 0;
    chk({name, "_end_valid"}, out_valid, 0);
    chk({name, "_end_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{"ones_zero", 16'hFFFF, 16'h0000, 4'hF, 4'h0};
    tv[1] = '{"f731",      16'hF731, 16'h0000, 4'h3, 4'h0};
    tv[2] = '{"f731_again",16'hF731, 16'h0000, 4'h3, 4'h0};
    tv[3] = '{"mixed",     16'hAA5A, 16'hFEC8, 4'hA, 4'hC};
    tv[4] = '{"zeros",     16'h0000, 16'h0000, 4'h0, 4'h0};
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 0;
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) frame(tv[v].f0[15-4*j -: 4], tv[v].f1[15-4*j -: 4]);
      chk({tv[v].name, "_latency"}, out_valid, 1);
      chk({tv[v].name, "_drain_ready"}, in_ready, 0);
      recv({tv[v].name, "_b0"}, tv[v].e0, 0);
      recv({tv[v].name, "_b1"}, tv[v].e1, 1);
      done(tv[v].name);
    end
    // stall during drain, with in_valid asserted that must not be consumed
    repeat (4) frame(4'hF, 4'h0);
    out_ready = 0; in_valid = 1; in_pix = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("stall_pix", out_pix, 4'hF);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 0; in_pix = 4'h0; out_ready = 1;
    chk("tput_b0_pix", out_pix, 4'hF);
    @(negedge clk);
    chk("tput_b1_valid", out_valid, 1);
    chk("tput_b1_pix", out_pix, 4'h0);
    chk("tput_b1_last", out_last, 1);
    @(negedge clk);
    done("tput");
    // misaligned in_last: short frame then missing in_last
    send(4'hF, 1);
    chk("ferr_short", frame_err, 1);
    send(4'hF, 0);
    chk("ferr_clean", frame_err, 0);
    send(4'hF, 0);
    chk("ferr_missing", frame_err, 1);
    frame(4'hF, 4'hF);
    frame(4'hF, 4'h0);
    chk("ferr_latency", out_valid, 1);
    recv("ferr_b0", 4'hF, 0);
    recv("ferr_b1", 4'h0, 1);
    done("ferr");
    // reset mid-frame discards counts, frame index and beat index
    frame(4'hF, 4'hF);
    frame(4'hF, 4'hF);
    send(4'hF, 0);
    rst = 1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_pix", out_pix, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 0;
    send(4'hF, 0);
    chk("post_rst_ferr", frame_err, 0);
    send(4'hF, 1);
    repeat (3) frame(4'h0, 4'h0);
    chk("post_rst_latency", out_valid, 1);
    recv("post_rst_b0", 4'h0, 0);
    recv("post_rst_b1", 4'h0, 1);
    done("post_rst");
`ifdef PIXDEC_WATERMARK_EN
    watmk = 8'h0F;
    repeat (4) frame(4'hF, 4'hF);
    recv("wm_b0", 4'h0, 0);
    recv("wm_b1", 4'hF, 1);
    done("wm");
    watmk = '0;
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
